// File: rtl/multi_producer_pkg.sv
// rtl/multi_producer_pkg.sv - shared flush FSM state, tag width and tag decode for multi_producer
package multi_producer_pkg;

    // Upper ID bits carry the channel tag (channel index + 1).
    localparam int TAG_W = 4;

    typedef enum logic [1:0] {
        ARMED = 2'd0,
        FIRE  = 2'd1,
        DONE  = 2'd2
    } flush_state_e;

    typedef struct packed {
        logic             hit;
        logic [TAG_W-1:0] ch;
    } tag_dec_t;

    // Tag 0 and tags beyond the channel count name no channel.
    function automatic tag_dec_t decode_tag(input logic [TAG_W-1:0] tag, input int num_ch);
        tag_dec_t d;
        d.hit = (tag != '0) && (int'(tag) <= num_ch);
        d.ch  = tag - TAG_W'(1);
        return d;
    endfunction

endpackage

// File: rtl/producer_channel.sv
// rtl/producer_channel.sv - one channel of address/ID/valid generation with stall hold and optional replay rewind
//
// Ports: clk, reset (async, active-high); stall, enable (issue control);
//        flush_req, flush_seq (replay build only: rewind to flush_seq on this edge);
//        address, id, valid (registered stream outputs).
// Macro: MULTI_PRODUCER_REPLAY_EN adds the replay rewind.
module producer_channel
    import multi_producer_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 16,
    parameter int ID_WIDTH      = 8,
    parameter int ADDR_STEP     = 4,
    parameter int CH_TAG        = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      stall,
    input  logic                      enable,
`ifdef MULTI_PRODUCER_REPLAY_EN
    input  logic                      flush_req,
    input  logic [ID_WIDTH-TAG_W-1:0] flush_seq,
`endif
    output logic [ADDRESS_WIDTH-1:0]  address,
    output logic [ID_WIDTH-1:0]       id,
    output logic                      valid
);

    localparam int                       SEQ_W = ID_WIDTH - TAG_W;
    localparam logic [ADDRESS_WIDTH-1:0] STEP  = ADDRESS_WIDTH'(ADDR_STEP);
    localparam logic [TAG_W-1:0]         TAG   = TAG_W'(CH_TAG);

    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [SEQ_W-1:0]         seq_q, seq_d, seq_inc;
    logic [ID_WIDTH-1:0]      id_q, id_d;
    logic                     valid_q, valid_d;
`ifdef MULTI_PRODUCER_REPLAY_EN
    logic [SEQ_W-1:0]         rewind_beats;
`endif

    always_comb begin
        addr_d  = addr_q;
        seq_d   = seq_q;
        id_d    = id_q;
        valid_d = valid_q;
        seq_inc = seq_q + SEQ_W'(1);
`ifdef MULTI_PRODUCER_REPLAY_EN
        // Beats issued from flush_seq up to and including the current one.
        rewind_beats = seq_q - flush_seq + SEQ_W'(1);
`endif
        if (!stall) begin
            if (enable) begin
                seq_d   = seq_inc;
                addr_d  = addr_q + STEP;
                id_d    = {TAG, seq_inc};
                valid_d = 1'b1;
            end else begin
                valid_d = 1'b0;
            end
        end
`ifdef MULTI_PRODUCER_REPLAY_EN
        // A flush overrides stall and issue: bubble for one cycle, and back up
        // so the next issued beat repeats flush_seq at its original address.
        if (flush_req) begin
            valid_d = 1'b0;
            seq_d   = flush_seq - SEQ_W'(1);
            addr_d  = addr_q - (STEP * ADDRESS_WIDTH'(rewind_beats));
            id_d    = id_q;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            seq_q   <= '0;
            id_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            seq_q   <= seq_d;
            id_q    <= id_d;
            valid_q <= valid_d;
        end
    end

    assign address = addr_q;
    assign id      = id_q;
    assign valid   = valid_q;

endmodule

// File: rtl/multi_producer.sv
// rtl/multi_producer.sv - NUM_CH stall-aware traffic streams with scheduled and external flush pulses
//
// Ports: clk, reset (async, active-high);
//        in_stall, ch_enable (per-channel control, NUM_CH bits);
//        out_address, out_id, out_valid (channel c at slice c of each bus);
//        ext_flush_valid, ext_flush_id (external flush, tag selects the channel);
//        flush, flush_id (registered one-cycle flush pulse and flushed ID per channel).
// Macro: MULTI_PRODUCER_REPLAY_EN makes a flush rewind the flushed channel's stream.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 16
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 8
`endif

module multi_producer
    import multi_producer_pkg::*;
#(
    parameter int NUM_CH        = 2,
    parameter int ADDRESS_WIDTH = `ADDRESS_WIDTH,
    parameter int ID_WIDTH      = `ID_WIDTH,
    parameter int ADDR_STEP     = 4,
    parameter int FLUSH_DELAY   = 42,
    parameter int FLUSH_CH      = 0,
    parameter int FLUSH_SEQ     = 6
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_CH-1:0]                 in_stall,
    input  logic [NUM_CH-1:0]                 ch_enable,
    output logic [NUM_CH*ADDRESS_WIDTH-1:0]   out_address,
    output logic [NUM_CH*ID_WIDTH-1:0]        out_id,
    output logic [NUM_CH-1:0]                 out_valid,
    input  logic                              ext_flush_valid,
    input  logic [ID_WIDTH-1:0]               ext_flush_id,
    output logic [NUM_CH-1:0]                 flush,
    output logic [NUM_CH*ID_WIDTH-1:0]        flush_id
);

    localparam int                  SEQ_W    = ID_WIDTH - TAG_W;
    localparam int                  CNT_W    = (FLUSH_DELAY > 0) ? $clog2(FLUSH_DELAY + 1) : 1;
    localparam logic [CNT_W-1:0]    CNT_INIT = CNT_W'(FLUSH_DELAY);
    localparam logic [ID_WIDTH-1:0] SCHED_ID = {TAG_W'(FLUSH_CH + 1), SEQ_W'(FLUSH_SEQ)};
    localparam flush_state_e        STATE_INIT = (FLUSH_DELAY == 0) ? DONE : ARMED;

    flush_state_e               state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [NUM_CH-1:0]          flush_q, flush_d;
    logic [NUM_CH*ID_WIDTH-1:0] flush_id_q, flush_id_d;

    tag_dec_t                   ext_dec;
    logic                       ext_hit;
    logic                       sched_grant;
    logic                       grant_any;
    logic [TAG_W-1:0]           grant_ch;
    logic [ID_WIDTH-1:0]        grant_id;

    // Arbitration: an external request with a valid tag always wins; an
    // external request with a bad tag is dropped and does not block FIRE.
    always_comb begin
        ext_dec     = decode_tag(ext_flush_id[ID_WIDTH-1 -: TAG_W], NUM_CH);
        ext_hit     = ext_flush_valid && ext_dec.hit;
        sched_grant = 1'b0;
        grant_any   = 1'b0;
        grant_ch    = '0;
        grant_id    = '0;
        if (ext_hit) begin
            grant_any = 1'b1;
            grant_ch  = ext_dec.ch;
            grant_id  = ext_flush_id;
        end else if (state_q == FIRE) begin
            sched_grant = 1'b1;
            grant_any   = 1'b1;
            grant_ch    = TAG_W'(FLUSH_CH);
            grant_id    = SCHED_ID;
        end

        flush_d    = '0;
        flush_id_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (grant_any && (grant_ch == TAG_W'(c))) begin
                flush_d[c]                          = 1'b1;
                flush_id_d[c*ID_WIDTH +: ID_WIDTH]  = grant_id;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ARMED: begin
                if (cnt_q == '0) begin
                    state_d = FIRE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            FIRE: begin
                if (sched_grant) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = DONE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= STATE_INIT;
            cnt_q      <= CNT_INIT;
            flush_q    <= '0;
            flush_id_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            flush_q    <= flush_d;
            flush_id_q <= flush_id_d;
        end
    end

    assign flush    = flush_q;
    assign flush_id = flush_id_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        producer_channel #(
            .ADDRESS_WIDTH (ADDRESS_WIDTH),
            .ID_WIDTH      (ID_WIDTH),
            .ADDR_STEP     (ADDR_STEP),
            .CH_TAG        (c + 1)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .stall     (in_stall[c]),
            .enable    (ch_enable[c]),
`ifdef MULTI_PRODUCER_REPLAY_EN
            .flush_req (flush_d[c]),
            .flush_seq (grant_id[SEQ_W-1:0]),
`endif
            .address   (out_address[c*ADDRESS_WIDTH +: ADDRESS_WIDTH]),
            .id        (out_id[c*ID_WIDTH +: ID_WIDTH]),
            .valid     (out_valid[c])
        );
    end

endmodule

// File: tb/tb_multi_producer.sv
// tb/tb_multi_producer.sv - randomized self-checking bench for multi_producer against a behavioural model
`timescale 1ns/1ps
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 16
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 8
`endif

module tb_multi_producer;

    localparam int NUM_CH = 2;
    localparam int AW     = `ADDRESS_WIDTH;
    localparam int IW     = `ID_WIDTH;
    localparam int SEQ_W  = IW - 4;
    localparam int STEP   = 4;
    localparam int FDELAY = 42;
    localparam int FCH    = 0;
    localparam int FSEQ   = 6;
    localparam longint AMASK = (64'd1 << AW) - 1;
    localparam int     SMASK = (1 << SEQ_W) - 1;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_CH-1:0]        in_stall, ch_enable, out_valid, flush;
    logic [NUM_CH*AW-1:0]     out_address;
    logic [NUM_CH*IW-1:0]     out_id, flush_id;
    logic                     ext_flush_valid;
    logic [IW-1:0]            ext_flush_id;

    multi_producer #(
        .NUM_CH(NUM_CH), .ADDRESS_WIDTH(AW), .ID_WIDTH(IW), .ADDR_STEP(STEP),
        .FLUSH_DELAY(FDELAY), .FLUSH_CH(FCH), .FLUSH_SEQ(FSEQ)
    ) dut (
        .clk(clk), .reset(reset), .in_stall(in_stall), .ch_enable(ch_enable),
        .out_address(out_address), .out_id(out_id), .out_valid(out_valid),
        .ext_flush_valid(ext_flush_valid), .ext_flush_id(ext_flush_id),
        .flush(flush), .flush_id(flush_id)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: per-channel stream state and the flush expected this cycle.
    longint m_addr [NUM_CH];
    int     m_seq  [NUM_CH];
    int     m_id   [NUM_CH];
    bit     m_valid[NUM_CH];
    int     e_flush_ch;
    int     e_flush_id;
    bit     sched_done;
    int     k;

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_addr[c] = 0; m_seq[c] = 0; m_id[c] = 0; m_valid[c] = 0;
        end
        e_flush_ch = -1;
        e_flush_id = 0;
        sched_done = (FDELAY == 0);
        k = 0;
    endtask

    // Apply the rules for one clock edge, k counting edges since reset release.
    task automatic model_edge();
        int tag;
        k++;
        tag = int'(ext_flush_id[IW-1:SEQ_W]);
        e_flush_ch = -1;
        e_flush_id = 0;
        if (ext_flush_valid && tag >= 1 && tag <= NUM_CH) begin
            e_flush_ch = tag - 1;
            e_flush_id = int'(ext_flush_id);
        end else if (!sched_done && k >= FDELAY + 2) begin
            e_flush_ch = FCH;
            e_flush_id = ((FCH + 1) << SEQ_W) | FSEQ;
            sched_done = 1;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            bit replayed;
            replayed = 0;
`ifdef MULTI_PRODUCER_REPLAY_EN
            if (e_flush_ch == c) begin
                int fs, beats;
                fs        = e_flush_id & SMASK;
                beats     = (m_seq[c] - fs + 1) & SMASK;
                m_addr[c] = (m_addr[c] - longint'(STEP) * beats) & AMASK;
                m_seq[c]  = (fs - 1) & SMASK;
                m_valid[c] = 0;
                replayed  = 1;
            end
`endif
            if (!replayed && !in_stall[c]) begin
                if (ch_enable[c]) begin
                    m_seq[c]   = (m_seq[c] + 1) & SMASK;
                    m_addr[c]  = (m_addr[c] + STEP) & AMASK;
                    m_id[c]    = ((c + 1) << SEQ_W) | m_seq[c];
                    m_valid[c] = 1;
                end else begin
                    m_valid[c] = 0;
                end
            end
        end
    endtask

    task automatic check_all();
        for (int c = 0; c < NUM_CH; c++) begin
            check_val($sformatf("addr%0d k=%0d", c, k), out_address[c*AW +: AW], m_addr[c]);
            check_val($sformatf("id%0d k=%0d", c, k), out_id[c*IW +: IW], m_id[c]);
            check_val($sformatf("valid%0d k=%0d", c, k), out_valid[c], m_valid[c]);
            check_val($sformatf("flush%0d k=%0d", c, k), flush[c], (e_flush_ch == c));
            check_val($sformatf("flush_id%0d k=%0d", c, k), flush_id[c*IW +: IW],
                      (e_flush_ch == c) ? e_flush_id : 0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic set_rand(input int ext_pct);
        for (int c = 0; c < NUM_CH; c++) begin
            in_stall[c]  = ($urandom_range(0, 9) < 3);
            ch_enable[c] = ($urandom_range(0, 9) < 8);
        end
        ext_flush_valid = ($urandom_range(0, 99) < ext_pct);
        ext_flush_id    = IW'(($urandom_range(0, 3) << SEQ_W) | $urandom_range(0, SMASK));
    endtask

    initial begin
        reset = 1'b1;
        in_stall = '0; ch_enable = '0; ext_flush_valid = 1'b0; ext_flush_id = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all();
        reset = 1'b0;

        // Free-running streams, then explicit first-beat values.
        ch_enable = '1;
        step();
        check_val("first_addr0", out_address[AW-1:0], 4);
        check_val("first_id1", out_id[2*IW-1:IW], 8'h21);
        repeat (2) step();
        check_val("third_id0", out_id[IW-1:0], 8'h13);

        // Hold ch0 for three cycles while ch1 runs.
        in_stall = 2'b01;
        repeat (3) step();
        check_val("stall_addr0", out_address[AW-1:0], 12);
        in_stall = '0;

        // Two idle cycles on ch1, then resume.
        ch_enable = 2'b01;
        repeat (2) step();
        ch_enable = 2'b11;
        step();

        while (k < FDELAY + 1) begin
            set_rand(0);
            step();
        end

        // External flush collides with the scheduled FIRE window.
        ext_flush_valid = 1'b1;
        ext_flush_id    = 8'h25;
        step();
        check_val("ext_wins", flush, 2'b10);
        check_val("ext_wins_id", flush_id[2*IW-1:IW], 8'h25);
        ext_flush_valid = 1'b0;
        step();
        check_val("sched_next", flush, 2'b01);
        check_val("sched_next_id", flush_id[IW-1:0], 8'h16);
        ext_flush_valid = 1'b1;
        ext_flush_id    = 8'h35;
        step();
        check_val("bad_tag_dropped", flush, 2'b00);

        repeat (200) begin
            set_rand(25);
            step();
        end

        // Asynchronous reset in the middle of a cycle, then re-armed run.
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        reset = 1'b0;
        repeat (150) begin
            set_rand(15);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/multi_producer.md
# multi_producer

- Parametrised traffic source for the stall/flush test harness. Successor to the fixed two-channel producer.
- Drives NUM_CH independent address/ID/valid streams that each honour a per-channel stall.
- Per-channel enable gates issue.
- Flushes come from two sources: a programmable one-shot scheduler and an external trigger. Both are arbitrated onto per-channel flush pulses.
- Sits upstream of the consumer/stall-propagation logic and is the sole stimulus source for flush-during-stall experiments.

## Interface
Parameters:
- NUM_CH, 2, number of channels (1..15).
- ADDRESS_WIDTH, `ADDRESS_WIDTH, address width per channel.
- ID_WIDTH, `ID_WIDTH, ID width. Upper 4 bits = channel tag (c+1); lower SEQ_W = ID_WIDTH-4 bits = sequence.
- ADDR_STEP, 4, address increment per issued beat.
- FLUSH_DELAY, 42, cycles after reset before the scheduled flush. 0 disables the scheduled flush.
- FLUSH_CH, 0, channel targeted by the scheduled flush.
- FLUSH_SEQ, 6, sequence field of the scheduled flush ID.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_stall  in  NUM_CH  per-channel stall; bit c stalls channel c.
- ch_enable  in  NUM_CH  per-channel issue enable.
- out_address  out  NUM_CH*ADDRESS_WIDTH  channel c at slice [c*ADDRESS_WIDTH +: ADDRESS_WIDTH].
- out_id  out  NUM_CH*ID_WIDTH  channel c at slice [c*ID_WIDTH +: ID_WIDTH].
- out_valid  out  NUM_CH  per-channel valid.
- ext_flush_valid  in  1  external flush request, single-cycle.
- ext_flush_id  in  ID_WIDTH  ID to flush; the tag selects the channel.
- flush  out  NUM_CH  one-cycle flush pulse per channel.
- flush_id  out  NUM_CH*ID_WIDTH  flushed ID, valid only while flush[c]=1, 0 otherwise.

## Operation
- Reset values: all out_address, out_id, out_valid, flush, flush_id = 0. Internal seq = 0. Delay counter = FLUSH_DELAY. FSM = ARMED, or DONE if FLUSH_DELAY=0.
- Channel c, per edge:
  - in_stall[c]=1: address, ID and valid hold.
  - in_stall[c]=0, ch_enable[c]=1: seq <= seq+1 mod 2^SEQ_W; address <= address+ADDR_STEP mod 2^ADDRESS_WIDTH; out_id <= {c+1, seq+1}; valid <= 1.
  - in_stall[c]=0, ch_enable[c]=0: valid <= 0; address, seq and ID hold.
- Sequence and address wrap independently. Sequence wraps after 2^SEQ_W beats; address wraps at 2^ADDRESS_WIDTH.
- Flush scheduler FSM:
  - ARMED: counter decrements each cycle. When the counter is 0, go to FIRE.
  - FIRE: request a flush of FLUSH_CH with ID {FLUSH_CH+1, FLUSH_SEQ}. Go to DONE once the flush is granted.
  - DONE: terminal until reset.
- External flush: ext_flush_valid with tag t in 1..NUM_CH flushes channel t-1. A tag of 0 or greater than NUM_CH is silently dropped.
- Arbitration: the external request wins. A scheduled request in FIRE in the same cycle stays in FIRE and is granted on the next cycle without an external request.
- Flush output is registered: the request in cycle N gives flush[c]=1 in cycle N+1 for exactly one cycle. At most one flush bit is high per cycle.
- Flush generation ignores in_stall and ch_enable. Stalled channels still receive flush pulses.
- Reset mid-operation: all state returns to reset values asynchronously. A pending scheduled flush is re-armed with the full FLUSH_DELAY.

## Timing
- First beat: out_valid[c]=1 one edge after reset deasserts, if unstalled and enabled. Values are address ADDR_STEP, ID {c+1,1}.
- Stall-to-hold latency is zero: outputs at the edge where in_stall[c]=1 are unchanged.
- Scheduled flush: flush[FLUSH_CH] high in cycle FLUSH_DELAY+2 after reset release. Count the first post-reset edge as 1.
- External flush: latency is 1 cycle.

## Configuration
- Macro MULTI_PRODUCER_REPLAY_EN.
- Without the macro: a flush is a sideband pulse only. Streams are unaffected.
- With the macro, on the edge that sets flush[c]=1, channel c:
  - forces valid <= 0 (a one-cycle bubble, regardless of stall);
  - sets seq <= flushed_seq-1 mod 2^SEQ_W;
  - rewinds the address by ADDR_STEP*((cur_seq - flushed_seq + 1) mod 2^SEQ_W), mod 2^ADDRESS_WIDTH.
- The next unstalled, enabled beat therefore re-issues flushed_seq with its original address.

## Structure
- Shared package (multi_producer_pkg):
  - flush FSM state enum (ARMED, FIRE, DONE);
  - tag width constant (4);
  - tag-to-channel decode function.
- One sub-module, producer_channel: the per-channel address/seq/valid datapath, including the replay rewind. Instantiated NUM_CH times by a generate loop.
- The top level holds the flush FSM, the delay counter and the arbitration.

## Test plan
- NUM_CH=2, no stall, all enabled → ch0 emits address 4,8,12 with ID 0x11,0x12,0x13; ch1 emits ID 0x21,0x22,0x23.
- in_stall[0]=1 for 3 cycles starting at ID 0x13 → ch0 holds 0x13 and address 12 for 3 cycles; ch1 keeps advancing.
- ch_enable[1]=0 for 2 cycles → out_valid[1]=0 for those cycles; the next beat continues the sequence with no gap.
- Default parameters → flush[0]=1 with flush_id 0x16 for exactly one cycle at cycle 44; never again until reset.
- ext_flush_valid=1 with ID 0x25 in the same cycle as the scheduled FIRE → flush[1]/0x25 next cycle, then flush[0]/0x16 the cycle after. An ext ID of 0x35 produces no pulse.
- MULTI_PRODUCER_REPLAY_EN, ch0 at ID 0x19, external flush of 0x16 → one bubble, then ch0 emits 0x16 at address 24, then 0x17 at address 28.
